coso_beat_counter: RTL and testbench
====================================

// Module: coso_beat_counter
// PURPOSE
// Digitisation stage of the COSO TRNG, downstream of the matched-NAND ring oscillators and the beat sampling flip-flop.
// Clocked by the sampling oscillator. Measures the period of the beat signal in clk cycles.
// Extracts the low-order bits of each period as raw entropy and packs them into words.
// Words leave on a valid/ready stream. Per-period counts are exposed for on-line health testing.
// PARAMETERS
// CNT_WIDTH        8   width of the beat-period counter (saturating)
// BITS_PER_SAMPLE  1   LSBs of each period count appended to the output word (1..CNT_WIDTH)
// WORD_WIDTH       32  output word width; must be a multiple of BITS_PER_SAMPLE
// MIN_CNT          4   smallest legal period; shorter periods raise err_short
// PORTS
// clk        in   1           sampling oscillator clock; the only clock
// rst        in   1           synchronous, active-high reset
// en         in   1           1 = run; 0 = freeze packing and discard the in-flight period
// beat       in   1           beat signal from the sampling DFF (may be metastable)
// rnd_data   out  WORD_WIDTH  packed raw random word
// rnd_valid  out  1           rnd_data holds an unconsumed word
// rnd_ready  in   1           consumer accepts the word when rnd_valid & rnd_ready
// cnt_out    out  CNT_WIDTH   last measured period (health-test tap)
// cnt_valid  out  1           one-cycle pulse when cnt_out updates
// err_short  out  1           sticky: a period < MIN_CNT was measured
// err_sat    out  1           sticky: the counter saturated at 2^CNT_WIDTH-1
// err_ovf    out  1           sticky: a full word was dropped because the output register was occupied
// BEHAVIOUR
// - Reset: all outputs are 0. Counter, packer fill count and primed flag are 0. Sticky flags are cleared only by rst.
// - Input stage: beat -> b1 -> b2 (two flops, metastability filter). Edge = b1 & ~b2.
//   An edge is therefore seen 2 cycles after beat rises.
// - Counter cnt:
//   - On an edge: cnt <= 1.
//   - Otherwise: cnt <= cnt + 1, saturating at all-ones. Hitting all-ones sets err_sat.
// - Sample on edge, primed = 1:
//   - Period P = cnt, measured before reload. Next cycle: cnt_out <= P and cnt_valid = 1 for exactly one cycle.
//   - P < MIN_CNT: set err_short.
//   - Counter was saturated: set err_sat.
//   - In both error cases the bits are discarded; cnt_out still updates.
//   - Otherwise P[BITS_PER_SAMPLE-1:0] is shifted into the packer. New bits enter at the LSB; older bits move toward the MSB.
// - Edge with primed = 0 (first edge after reset or after en was low): sets primed only. No sample, no cnt_valid.
// - en = 0: primed <= 0 and edges are ignored. The counter keeps running. Packer contents and fill count are held.
//   The output stream keeps operating.
// - Packer: when WORD_WIDTH/BITS_PER_SAMPLE samples are collected, the word transfers to rnd_data on the following cycle.
//   - Transfer happens if rnd_valid = 0, or if rnd_valid & rnd_ready in that same cycle (back-to-back, no bubble).
//   - Otherwise the word is dropped, err_ovf is set, and the fill count restarts at 0.
// - Handshake: rnd_data is stable while rnd_valid & ~rnd_ready. rnd_valid falls after acceptance unless a new word loads in the same cycle.
// - Latency: from beat rise completing a word to rnd_valid = 4 clk cycles (2 sync, 1 sample, 1 transfer).
// - Consecutive edges are at least 2 cycles apart by construction. No simultaneous-edge case exists.
// TESTING
// - Reset: assert rst for 3 cycles with beat toggling -> all outputs 0, no cnt_valid.
// - Periodic beat, 10-cycle period, BITS_PER_SAMPLE=1, WORD_WIDTH=8:
//   - First edge is discarded; following edges each give cnt_out = 10.
//   - After 8 samples: rnd_data = 8'h00, rnd_valid = 1. Alternating periods 9/10 (9 first) -> rnd_data = 8'hAA.
// - Beat period 3 with MIN_CNT=4 -> cnt_out = 3, err_short = 1, no bits packed. Flag stays set until rst.
// - Beat held low for 300 cycles with CNT_WIDTH=8 -> err_sat = 1. The next edge is discarded; the following edge gives a valid sample.
// - Hold rnd_ready = 0 across two completed words -> first word held stable, second dropped, err_ovf = 1.
//   Then with rnd_ready = 1 the first word is accepted.
// - Drop en for 5 cycles mid-word -> fill count preserved, one edge re-primes, and the word completes with the correct remaining samples.

Source files
------------

// File: rtl/coso_beat_counter.sv
// COSO TRNG digitiser: measures beat-signal periods in sampling-clock cycles,
// packs the low-order bits of each period into words on a valid/ready stream.
module coso_beat_counter #(
    parameter int CNT_WIDTH       = 8,
    parameter int BITS_PER_SAMPLE = 1,
    parameter int WORD_WIDTH      = 32,
    parameter int MIN_CNT         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  beat,
    output logic [WORD_WIDTH-1:0] rnd_data,
    output logic                  rnd_valid,
    input  logic                  rnd_ready,
    output logic [CNT_WIDTH-1:0]  cnt_out,
    output logic                  cnt_valid,
    output logic                  err_short,
    output logic                  err_sat,
    output logic                  err_ovf
);

    localparam int                   SAMPLES   = WORD_WIDTH / BITS_PER_SAMPLE;
    localparam int                   FILL_W    = $clog2(SAMPLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MIN   = CNT_WIDTH'(MIN_CNT);
    localparam logic [FILL_W-1:0]    FILL_LAST = FILL_W'(SAMPLES - 1);

    // input synchroniser
    logic b1_q, b1_d;
    logic b2_q, b2_d;

    // period counter and priming
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 primed_q, primed_d;

    // sample stage
    logic [CNT_WIDTH-1:0]       cnt_out_q, cnt_out_d;
    logic                       cnt_valid_q, cnt_valid_d;
    logic                       smp_ok_q, smp_ok_d;
    logic [BITS_PER_SAMPLE-1:0] smp_bits_q, smp_bits_d;

    // packer and output register
    logic [WORD_WIDTH-1:0] pack_q, pack_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  full_q, full_d;
    logic [WORD_WIDTH-1:0] rnd_data_q, rnd_data_d;
    logic                  rnd_valid_q, rnd_valid_d;

    // sticky error flags
    logic err_short_q, err_short_d;
    logic err_sat_q, err_sat_d;
    logic err_ovf_q, err_ovf_d;

    logic edge_det;
    logic sample;
    logic short_p;
    logic sat_p;

    always_comb begin
        b1_d = beat;
        b2_d = b1_q;

        edge_det = b1_q & ~b2_q;
        short_p  = cnt_q < CNT_MIN;
        sat_p    = cnt_q == CNT_MAX;
        sample   = edge_det & en & primed_q;

        // The counter reloads on every physical edge, even while disabled,
        // so it always reflects the time since the last beat rise.
        if (edge_det) begin
            cnt_d = CNT_WIDTH'(1);
        end else if (sat_p) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        primed_d = en ? (primed_q | edge_det) : 1'b0;

        cnt_out_d   = sample ? cnt_q : cnt_out_q;
        cnt_valid_d = sample;
        smp_ok_d    = sample & ~short_p & ~sat_p;
        smp_bits_d  = cnt_q[BITS_PER_SAMPLE-1:0];

        err_short_d = err_short_q | (sample & short_p);
        err_sat_d   = err_sat_q | sat_p;
    end

    always_comb begin
        pack_d = pack_q;
        fill_d = fill_q;
        full_d = 1'b0;

        if (smp_ok_q) begin
            pack_d = (pack_q << BITS_PER_SAMPLE) | WORD_WIDTH'(smp_bits_q);
            if (fill_q == FILL_LAST) begin
                fill_d = '0;
                full_d = 1'b1;
            end else begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        rnd_data_d  = rnd_data_q;
        rnd_valid_d = rnd_valid_q & ~rnd_ready;
        err_ovf_d   = err_ovf_q;

        // pack_q still holds the completed word here even if a new sample
        // shifts in during this same cycle.
        if (full_q) begin
            if (!rnd_valid_q || rnd_ready) begin
                rnd_data_d  = pack_q;
                rnd_valid_d = 1'b1;
            end else begin
                err_ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b1_q        <= 1'b0;
            b2_q        <= 1'b0;
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            cnt_out_q   <= '0;
            cnt_valid_q <= 1'b0;
            smp_ok_q    <= 1'b0;
            smp_bits_q  <= '0;
            pack_q      <= '0;
            fill_q      <= '0;
            full_q      <= 1'b0;
            rnd_data_q  <= '0;
            rnd_valid_q <= 1'b0;
            err_short_q <= 1'b0;
            err_sat_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            cnt_out_q   <= cnt_out_d;
            cnt_valid_q <= cnt_valid_d;
            smp_ok_q    <= smp_ok_d;
            smp_bits_q  <= smp_bits_d;
            pack_q      <= pack_d;
            fill_q      <= fill_d;
            full_q      <= full_d;
            rnd_data_q  <= rnd_data_d;
            rnd_valid_q <= rnd_valid_d;
            err_short_q <= err_short_d;
            err_sat_q   <= err_sat_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign rnd_data  = rnd_data_q;
    assign rnd_valid = rnd_valid_q;
    assign cnt_out   = cnt_out_q;
    assign cnt_valid = cnt_valid_q;
    assign err_short = err_short_q;
    assign err_sat   = err_sat_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_coso_beat_counter.sv
// Directed bench for coso_beat_counter: CNT_WIDTH=8, 1 bit/sample, 8-bit words, MIN_CNT=4.
module tb_coso_beat_counter;

    logic       clk = 1'b0;
    logic       rst, en, beat, rnd_ready;
    logic [7:0] rnd_data;
    logic       rnd_valid;
    logic [7:0] cnt_out;
    logic       cnt_valid, err_short, err_sat, err_ovf;

    int checks = 0;
    int errors = 0;
    int cv_cnt = 0;
    int cv_base;

    int ovf_seq [16] = '{9, 9, 10, 10, 9, 10, 9, 9, 9, 9, 9, 9, 9, 9, 9, 10};
    int aa_seq  [9]  = '{9, 10, 9, 10, 9, 10, 9, 10, 10};
    int en_pre  [4]  = '{9, 10, 9, 10};
    int en_post [6]  = '{10, 10, 9, 9, 10, 10};

    coso_beat_counter #(
        .CNT_WIDTH(8), .BITS_PER_SAMPLE(1), .WORD_WIDTH(8), .MIN_CNT(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .beat(beat),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .cnt_out(cnt_out), .cnt_valid(cnt_valid),
        .err_short(err_short), .err_sat(err_sat), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst && cnt_valid) cv_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // beat high one cycle, low for the rest; rises are p cycles apart
    task automatic pulse(input int p);
        beat = 1'b1;
        tick();
        beat = 1'b0;
        repeat (p - 1) tick();
    endtask

    task automatic gap();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
    endtask

    task automatic accept(input string tag);
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
        chk(tag, rnd_valid, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; beat = 1'b0; rnd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat = ~beat;
            tick();
            chk("rst_flags", {rnd_valid, cnt_valid, err_short, err_sat, err_ovf}, 0);
            chk("rst_data", rnd_data, 0);
            chk("rst_cnt", cnt_out, 0);
        end
        beat = 1'b0;
        tick();
        rst = 1'b0;
        en  = 1'b1;
        repeat (2) tick();
        chk("rst_cv", cv_cnt, 0);

        // periodic 10: prime + 7 samples, 8th sample driven by hand for latency
        for (int i = 0; i < 8; i++) pulse(10);
        chk("p10_nword", rnd_valid, 0);
        beat = 1'b1;
        tick();
        beat = 1'b0;
        tick();
        chk("p10_cv", cnt_valid, 1);
        chk("p10_cnt", cnt_out, 10);
        tick();
        chk("lat3", rnd_valid, 0);
        tick();
        chk("lat4", rnd_valid, 1);
        repeat (6) tick();
        chk("p10_word", rnd_data, 8'h00);
        chk("p10_ncv", cv_cnt, 8);
        accept("p10_acc");

        // alternating 9/10 -> AA
        gap();
        for (int i = 0; i < 9; i++) pulse(aa_seq[i]);
        chk("aa_valid", rnd_valid, 1);
        chk("aa_word", rnd_data, 8'hAA);
        chk("aa_short0", err_short, 0);
        accept("aa_acc");

        // short period
        gap();
        cv_base = cv_cnt;
        pulse(3); pulse(3); pulse(10);
        chk("sh_cnt", cnt_out, 3);
        chk("sh_err", err_short, 1);
        chk("sh_ncv", cv_cnt - cv_base, 2);
        chk("sh_nword", rnd_valid, 0);
        chk("sh_sat0", err_sat, 0);

        // saturation, then two words with ready low
        gap();
        cv_base = cv_cnt;
        pulse(300);
        chk("sat_err", err_sat, 1);
        chk("sat_ncv", cv_cnt - cv_base, 0);
        pulse(10);
        chk("sat_cnt", cnt_out, 8'hFF);
        pulse(ovf_seq[0]);
        chk("sat_next", cnt_out, 10);
        chk("ovf_pre", err_ovf, 0);
        for (int i = 1; i < 16; i++) pulse(ovf_seq[i]);
        chk("ovf_err", err_ovf, 1);
        chk("ovf_valid", rnd_valid, 1);
        chk("ovf_word", rnd_data, 8'h65);
        accept("ovf_acc");

        // en dropped for 5 cycles after 3 samples
        gap();
        cv_base = cv_cnt;
        for (int i = 0; i < 4; i++) pulse(en_pre[i]);
        en = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        chk("en_nword", rnd_valid, 0);
        for (int i = 0; i < 6; i++) pulse(en_post[i]);
        chk("en_ncv", cv_cnt - cv_base, 8);
        chk("en_valid", rnd_valid, 1);
        chk("en_word", rnd_data, 8'hA6);

        chk("sticky", {err_short, err_sat, err_ovf}, 3'b111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_flags", {rnd_valid, cnt_valid, err_short, err_sat, err_ovf}, 0);
        chk("rst2_data", {rnd_data, cnt_out}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
